// File: rtl/hazard_scoreboard_ctrl.sv
// hazard_scoreboard_ctrl
//   Pipeline hazard and control unit with a scoreboard of outstanding
//   long-latency writebacks (mul/div, slow loads) that complete out of band.
//   Produces RAW / WAW / structural stalls, branch flush, external freeze,
//   and drains the scoreboard before acknowledging an interrupt. Drives all
//   pipeline register enables and synchronous clears.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   rs1_id, rs2_id, use_rs*_id    ID-stage sources and their use flags
//   rd_id, reg_write_id           ID-stage destination and write flag
//   rd_exe, mem_read_exe, long_exe EXE-stage destination and op class
//   alloc_valid                   long op leaves EXE, allocate an entry
//   cmpl_valid, cmpl_tag          long unit writeback, entry to free
//   pc_sel_mem                    taken branch/jump resolved in MEM
//   stall_pipl                    external freeze
//   interrupt                     level interrupt request
//   alloc_tag                     lowest free entry (0 when full)
//   sb_full, sb_empty             scoreboard occupancy flags
//   irq_ack                       one-cycle interrupt acknowledge
//   *_reg_en, *_reg_clr           pipeline register enables / clears
//   stall_count                   saturating count of cycles with pc_reg_en=0
module hazard_scoreboard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_TAGS   = 4,
   parameter int TAG_W      = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [REG_ADDR_W-1:0] rs1_id,
   input  logic [REG_ADDR_W-1:0] rs2_id,
   input  logic                  use_rs1_id,
   input  logic                  use_rs2_id,
   input  logic [REG_ADDR_W-1:0] rd_id,
   input  logic                  reg_write_id,
   input  logic [REG_ADDR_W-1:0] rd_exe,
   input  logic                  mem_read_exe,
   input  logic                  long_exe,
   input  logic                  alloc_valid,
   input  logic                  cmpl_valid,
   input  logic [TAG_W-1:0]      cmpl_tag,
   input  logic                  pc_sel_mem,
   input  logic                  stall_pipl,
   input  logic                  interrupt,
   output logic [TAG_W-1:0]      alloc_tag,
   output logic                  sb_full,
   output logic                  sb_empty,
   output logic                  irq_ack,
   output logic                  pc_reg_en,
   output logic                  if_id_reg_en,
   output logic                  id_exe_reg_en,
   output logic                  exe_mem_reg_en,
   output logic                  mem_wb_reg_en,
   output logic                  if_id_reg_clr,
   output logic                  id_exe_reg_clr,
   output logic                  exe_mem_reg_clr,
   output logic                  mem_wb_reg_clr,
   output logic [CNT_W-1:0]      stall_count
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      ACK   = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [NUM_TAGS-1:0]   sb_valid;
   logic [REG_ADDR_W-1:0] sb_rd [NUM_TAGS];
   logic                  alloc_we;
   logic                  hit_rs1;
   logic                  hit_rs2;
   logic                  hit_rd;
   logic                  raw_hz;
   logic                  waw_hz;
   logic                  struct_hz;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign sb_full  = &sb_valid;
   assign sb_empty = ~|sb_valid;

   // Lowest-index free entry wins; scanning downward leaves the lowest last.
   always_comb begin
      alloc_tag = '0;
      for (int i = NUM_TAGS - 1; i >= 0; i--) begin
         if (!sb_valid[i]) alloc_tag = TAG_W'(i);
      end
   end

   // rd_exe == 0 never produces a result worth tracking.
   assign alloc_we = alloc_valid && (rd_exe != '0) && !sb_full;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sb_valid <= '0;
      end else begin
         // Completion of an already-free entry is a no-op. An allocation
         // always targets a free entry, so assigning it last cannot be undone
         // by a stale completion to the same slot.
         if (cmpl_valid && (int'(cmpl_tag) < NUM_TAGS)) sb_valid[cmpl_tag] <= 1'b0;
         if (alloc_we) sb_valid[alloc_tag] <= 1'b1;
      end
   end

   // Destination fields are qualified by sb_valid and need no reset.
   always_ff @(posedge clk) begin
      if (alloc_we) sb_rd[alloc_tag] <= rd_exe;
   end

   always_comb begin
      hit_rs1 = 1'b0;
      hit_rs2 = 1'b0;
      hit_rd  = 1'b0;
      for (int i = 0; i < NUM_TAGS; i++) begin
         if (sb_valid[i]) begin
            if (sb_rd[i] == rs1_id) hit_rs1 = 1'b1;
            if (sb_rd[i] == rs2_id) hit_rs2 = 1'b1;
            if (sb_rd[i] == rd_id)  hit_rd  = 1'b1;
         end
      end
   end

   // The EXE-stage producer comparison needs no rd_exe != 0 term: the source
   // is already known non-zero, so equality implies a real register.
   always_comb begin
      raw_hz = 1'b0;
      if (use_rs1_id && (rs1_id != '0) &&
          (hit_rs1 || ((long_exe || mem_read_exe) && (rd_exe == rs1_id))))
         raw_hz = 1'b1;
      if (use_rs2_id && (rs2_id != '0) &&
          (hit_rs2 || ((long_exe || mem_read_exe) && (rd_exe == rs2_id))))
         raw_hz = 1'b1;
   end

   assign waw_hz    = reg_write_id && (rd_id != '0) && hit_rd;
   assign struct_hz = long_exe && sb_full;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= RUN;
      else          state <= state_nxt;
   end

   // A flush during DRAIN holds the FSM in DRAIN for that cycle so the
   // acknowledge is never taken alongside a redirect.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:   if (interrupt) state_nxt = DRAIN;
         DRAIN: begin
            if (!interrupt)
               state_nxt = RUN;
            else if (pc_sel_mem)
               state_nxt = DRAIN;
            else if (sb_empty && !long_exe && !stall_pipl)
               state_nxt = ACK;
         end
         ACK:     state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   assign irq_ack = (state == ACK);

   always_comb begin
      pc_reg_en       = 1'b1;
      if_id_reg_en    = 1'b1;
      id_exe_reg_en   = 1'b1;
      exe_mem_reg_en  = 1'b1;
      mem_wb_reg_en   = 1'b1;
      if_id_reg_clr   = 1'b0;
      id_exe_reg_clr  = 1'b0;
      exe_mem_reg_clr = 1'b0;
      mem_wb_reg_clr  = 1'b0;
      if (stall_pipl) begin
         pc_reg_en      = 1'b0;
         if_id_reg_en   = 1'b0;
         id_exe_reg_en  = 1'b0;
         exe_mem_reg_en = 1'b0;
         mem_wb_reg_en  = 1'b0;
      end else if (pc_sel_mem) begin
         if_id_reg_clr   = 1'b1;
         id_exe_reg_clr  = 1'b1;
         exe_mem_reg_clr = 1'b1;
      end else if (struct_hz) begin
         // Hold the front end; a bubble goes into MEM while WB drains.
         pc_reg_en       = 1'b0;
         if_id_reg_en    = 1'b0;
         id_exe_reg_en   = 1'b0;
         exe_mem_reg_en  = 1'b0;
         exe_mem_reg_clr = 1'b1;
      end else if (raw_hz || waw_hz) begin
         pc_reg_en      = 1'b0;
         if_id_reg_en   = 1'b0;
         id_exe_reg_clr = 1'b1;
      end else if (state == DRAIN) begin
         // Stop fetching and let everything already issued retire.
         pc_reg_en     = 1'b0;
         if_id_reg_clr = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)        stall_count <= '0;
      else if (!pc_reg_en) stall_count <= sat_inc(stall_count);
   end

   a_alloc_when_full: assert property (@(posedge clk) disable iff (!reset_n)
      !(alloc_valid && sb_full))
      else $error("alloc_valid asserted while scoreboard full");

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Testbench for hazard_scoreboard_ctrl: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_hazard_scoreboard_ctrl;

   localparam int RAW_W = 5;
   localparam int NT    = 4;
   localparam int TW    = 2;
   localparam int CW    = 4;
   localparam int CMAX  = 15;

   logic            clk;
   logic            reset_n;
   logic [RAW_W-1:0] rs1_id, rs2_id, rd_id, rd_exe;
   logic            use_rs1_id, use_rs2_id, reg_write_id;
   logic            mem_read_exe, long_exe, alloc_valid, cmpl_valid;
   logic [TW-1:0]   cmpl_tag;
   logic            pc_sel_mem, stall_pipl, interrupt;
   logic [TW-1:0]   alloc_tag;
   logic            sb_full, sb_empty, irq_ack;
   logic            pc_reg_en, if_id_reg_en, id_exe_reg_en, exe_mem_reg_en, mem_wb_reg_en;
   logic            if_id_reg_clr, id_exe_reg_clr, exe_mem_reg_clr, mem_wb_reg_clr;
   logic [CW-1:0]   stall_count;

   int n_checks;
   int n_errors;

   hazard_scoreboard_ctrl #(
      .REG_ADDR_W (RAW_W),
      .NUM_TAGS   (NT),
      .TAG_W      (TW),
      .CNT_W      (CW)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .rs1_id          (rs1_id),
      .rs2_id          (rs2_id),
      .use_rs1_id      (use_rs1_id),
      .use_rs2_id      (use_rs2_id),
      .rd_id           (rd_id),
      .reg_write_id    (reg_write_id),
      .rd_exe          (rd_exe),
      .mem_read_exe    (mem_read_exe),
      .long_exe        (long_exe),
      .alloc_valid     (alloc_valid),
      .cmpl_valid      (cmpl_valid),
      .cmpl_tag        (cmpl_tag),
      .pc_sel_mem      (pc_sel_mem),
      .stall_pipl      (stall_pipl),
      .interrupt       (interrupt),
      .alloc_tag       (alloc_tag),
      .sb_full         (sb_full),
      .sb_empty        (sb_empty),
      .irq_ack         (irq_ack),
      .pc_reg_en       (pc_reg_en),
      .if_id_reg_en    (if_id_reg_en),
      .id_exe_reg_en   (id_exe_reg_en),
      .exe_mem_reg_en  (exe_mem_reg_en),
      .mem_wb_reg_en   (mem_wb_reg_en),
      .if_id_reg_clr   (if_id_reg_clr),
      .id_exe_reg_clr  (id_exe_reg_clr),
      .exe_mem_reg_clr (exe_mem_reg_clr),
      .mem_wb_reg_clr  (mem_wb_reg_clr),
      .stall_count     (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // Scoreboard as plain arrays, interrupt handshake as a small mode number
   // (0 running, 1 draining, 2 acknowledging).
   bit m_valid [NT];
   int m_rd    [NT];
   int m_mode;
   int m_cnt;

   int e_tag;
   bit e_full, e_empty, e_ack;
   logic [4:0] e_en;   // {pc, if_id, id_exe, exe_mem, mem_wb}
   logic [3:0] e_clr;  // {if_id, id_exe, exe_mem, mem_wb}

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NT; i++) begin
         m_valid[i] = 0;
         m_rd[i]    = 0;
      end
      m_mode = 0;
      m_cnt  = 0;
   endtask

   function automatic bit pending(input int r);
      for (int i = 0; i < NT; i++)
         if (m_valid[i] && m_rd[i] == r) return 1;
      return 0;
   endfunction

   task automatic model_eval();
      int  used;
      bit  raw, waw, strct, exe_prod;
      used  = 0;
      e_tag = 0;
      for (int i = NT - 1; i >= 0; i--) begin
         if (m_valid[i]) used++;
         else e_tag = i;
      end
      e_full   = (used == NT);
      e_empty  = (used == 0);
      e_ack    = (m_mode == 2);
      exe_prod = long_exe || mem_read_exe;
      raw = (use_rs1_id && rs1_id != 0 && (pending(int'(rs1_id)) || (exe_prod && rd_exe == rs1_id))) ||
            (use_rs2_id && rs2_id != 0 && (pending(int'(rs2_id)) || (exe_prod && rd_exe == rs2_id)));
      waw   = reg_write_id && rd_id != 0 && pending(int'(rd_id));
      strct = long_exe && e_full;
      if (stall_pipl) begin
         e_en = 5'b00000; e_clr = 4'b0000;
      end else if (pc_sel_mem) begin
         e_en = 5'b11111; e_clr = 4'b1110;
      end else if (strct) begin
         e_en = 5'b00001; e_clr = 4'b0010;
      end else if (raw || waw) begin
         e_en = 5'b00111; e_clr = 4'b0100;
      end else if (m_mode == 1) begin
         e_en = 5'b01111; e_clr = 4'b1000;
      end else begin
         e_en = 5'b11111; e_clr = 4'b0000;
      end
   endtask

   task automatic model_clock();
      if (!reset_n) begin
         model_reset();
      end else begin
         if (cmpl_valid && int'(cmpl_tag) < NT) m_valid[cmpl_tag] = 0;
         if (alloc_valid && rd_exe != 0 && !e_full) begin
            m_valid[e_tag] = 1;
            m_rd[e_tag]    = int'(rd_exe);
         end
         case (m_mode)
            0: if (interrupt) m_mode = 1;
            1: if (!interrupt) m_mode = 0;
               else if (!pc_sel_mem && e_empty && !long_exe && !stall_pipl) m_mode = 2;
            default: m_mode = 0;
         endcase
         if (e_en[4] == 1'b0 && m_cnt < CMAX) m_cnt++;
      end
   endtask

   task automatic compare_all();
      model_eval();
      check_val("en",        {pc_reg_en, if_id_reg_en, id_exe_reg_en, exe_mem_reg_en, mem_wb_reg_en}, e_en);
      check_val("clr",       {if_id_reg_clr, id_exe_reg_clr, exe_mem_reg_clr, mem_wb_reg_clr}, e_clr);
      check_val("alloc_tag", alloc_tag, e_tag);
      check_val("sb_full",   sb_full, e_full);
      check_val("sb_empty",  sb_empty, e_empty);
      check_val("irq_ack",   irq_ack, e_ack);
      check_val("stall_cnt", stall_count, m_cnt);
   endtask

   // Inputs are set at posedge+1; outputs compared at the negedge; the model
   // advances on the posedge.
   task automatic cycle();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic idle_inputs();
      rs1_id = 0; rs2_id = 0; rd_id = 0; rd_exe = 0;
      use_rs1_id = 0; use_rs2_id = 0; reg_write_id = 0;
      mem_read_exe = 0; long_exe = 0; alloc_valid = 0;
      cmpl_valid = 0; cmpl_tag = 0;
      pc_sel_mem = 0; stall_pipl = 0; interrupt = 0;
   endtask

   task automatic alloc_one(input int r);
      alloc_valid = 1; long_exe = 1; rd_exe = RAW_W'(r);
      cycle();
      alloc_valid = 0; long_exe = 0; rd_exe = 0;
   endtask

   task automatic complete_one(input int t);
      cmpl_valid = 1; cmpl_tag = TW'(t);
      cycle();
      cmpl_valid = 0; cmpl_tag = 0;
   endtask

   initial begin
      int acks;
      bit r_full;
      n_checks = 0;
      n_errors = 0;
      idle_inputs();
      reset_n = 0;
      model_reset();
      #12;
      compare_all();
      check_val("rst_en", {pc_reg_en, if_id_reg_en, id_exe_reg_en, exe_mem_reg_en, mem_wb_reg_en}, 5'b11111);
      check_val("rst_empty", sb_empty, 1);
      cycle();
      reset_n = 1;

      // Fill all four entries, then a long op hits the structural stall.
      for (int i = 0; i < NT; i++) begin
         alloc_valid = 1; long_exe = 1; rd_exe = RAW_W'(5 + i);
         #1;
         check_val("alloc_seq", alloc_tag, i);
         cycle();
      end
      alloc_valid = 0; rd_exe = 0; long_exe = 1;
      #1;
      check_val("full", sb_full, 1);
      check_val("struct_clr", exe_mem_reg_clr, 1);
      check_val("struct_pc_en", pc_reg_en, 0);
      cycle();
      long_exe = 0;
      for (int i = 0; i < NT; i++) complete_one(i);

      // RAW stall on a pending entry until it completes.
      alloc_one(5);
      use_rs1_id = 1; rs1_id = 5;
      repeat (3) begin
         #1;
         check_val("raw_pc_en", pc_reg_en, 0);
         check_val("raw_id_exe_clr", id_exe_reg_clr, 1);
         cycle();
      end
      cmpl_valid = 1; cmpl_tag = 0;
      #1;
      check_val("raw_cmpl_cycle", pc_reg_en, 0);
      cycle();
      cmpl_valid = 0;
      #1;
      check_val("raw_released", pc_reg_en, 1);
      cycle();
      use_rs1_id = 0; rs1_id = 0;

      // rd=0 allocation tracks nothing; then WAW and priority overrides.
      alloc_valid = 1; long_exe = 1; rd_exe = 0; use_rs2_id = 1; rs2_id = 0;
      #1;
      check_val("rd0_no_stall", pc_reg_en, 1);
      cycle();
      alloc_valid = 0; long_exe = 0; use_rs2_id = 0;
      #1;
      check_val("rd0_empty", sb_empty, 1);
      alloc_one(6);
      reg_write_id = 1; rd_id = 6;
      #1;
      check_val("waw_pc_en", pc_reg_en, 0);
      pc_sel_mem = 1;
      #1;
      check_val("flush_en", {pc_reg_en, if_id_reg_en, id_exe_reg_en, exe_mem_reg_en, mem_wb_reg_en}, 5'b11111);
      check_val("flush_clr", {if_id_reg_clr, id_exe_reg_clr, exe_mem_reg_clr, mem_wb_reg_clr}, 4'b1110);
      stall_pipl = 1;
      #1;
      check_val("freeze_en", {pc_reg_en, if_id_reg_en, id_exe_reg_en, exe_mem_reg_en, mem_wb_reg_en}, 5'b00000);
      check_val("freeze_clr", {if_id_reg_clr, id_exe_reg_clr, exe_mem_reg_clr, mem_wb_reg_clr}, 4'b0000);
      cycle();
      idle_inputs();
      complete_one(0);

      // Interrupt drain with two pending entries.
      alloc_one(9);
      alloc_one(10);
      interrupt = 1;
      cycle();
      #1;
      check_val("drain_if_id_clr", if_id_reg_clr, 1);
      check_val("drain_pc_en", pc_reg_en, 0);
      complete_one(0);
      complete_one(1);
      acks = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (irq_ack) begin
            acks++;
            interrupt = 0;
         end
         cycle();
      end
      check_val("irq_pulses", acks, 1);
      idle_inputs();

      // Asynchronous reset in the middle of a drain.
      alloc_one(11);
      alloc_one(12);
      interrupt = 1;
      cycle();
      cycle();
      interrupt = 0;
      #2;
      reset_n = 0;
      model_reset();
      #1;
      check_val("rst_mid_empty", sb_empty, 1);
      check_val("rst_mid_pc_en", pc_reg_en, 1);
      check_val("rst_mid_ifid_clr", if_id_reg_clr, 0);
      check_val("rst_mid_cnt", stall_count, 0);
      cycle();
      reset_n = 1;

      // Counter saturation.
      stall_pipl = 1;
      repeat (10) cycle();
      #1;
      check_val("cnt_10", stall_count, 10);
      repeat (10) cycle();
      #1;
      check_val("cnt_sat", stall_count, CMAX);
      stall_pipl = 0;
      cycle();

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         if (n % 500 == 499) begin
            idle_inputs();
            reset_n = 0;
            model_reset();
            cycle();
            reset_n = 1;
         end
         r_full = 1;
         for (int i = 0; i < NT; i++) if (!m_valid[i]) r_full = 0;
         alloc_valid  = !r_full && ($urandom_range(0, 2) == 0);
         long_exe     = alloc_valid || ($urandom_range(0, 4) == 0);
         rd_exe       = RAW_W'($urandom_range(0, 7));
         mem_read_exe = ($urandom_range(0, 4) == 0);
         cmpl_valid   = ($urandom_range(0, 2) == 0);
         cmpl_tag     = TW'($urandom_range(0, NT - 1));
         use_rs1_id   = $urandom_range(0, 1) == 1;
         use_rs2_id   = $urandom_range(0, 1) == 1;
         rs1_id       = RAW_W'($urandom_range(0, 7));
         rs2_id       = RAW_W'($urandom_range(0, 7));
         reg_write_id = $urandom_range(0, 1) == 1;
         rd_id        = RAW_W'($urandom_range(0, 7));
         pc_sel_mem   = ($urandom_range(0, 9) == 0);
         stall_pipl   = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 15) == 0) interrupt = !interrupt;
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard_ctrl.md
Name: hazard_scoreboard_ctrl

Overview:
Parametrised successor to the fixed 5-stage hazard/pipeline control path in the core. It adds a scoreboard of outstanding long-latency writebacks (mul/div, slow loads) that complete out of band. From the scoreboard it produces RAW, WAW and structural stalls, handles branch flush and external freeze, and drains the scoreboard before acknowledging an interrupt. It sits in the control unit beside the forwarding unit and drives every pipeline register enable and clear.

Parameters:
REG_ADDR_W, 5, register index width (register 0 is hardwired zero and is never tracked).
NUM_TAGS, 4, maximum outstanding long-latency operations (scoreboard entries), 1..16.
TAG_W, $clog2(NUM_TAGS) (minimum 1), tag width.
CNT_W, 16, stall performance-counter width.

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
rs1_id, rs2_id  in  REG_ADDR_W  ID-stage source registers
use_rs1_id, use_rs2_id  in  1  ID instruction actually reads rs1 / rs2
rd_id  in  REG_ADDR_W  ID-stage destination
reg_write_id  in  1  ID instruction writes rd
rd_exe  in  REG_ADDR_W  EXE-stage destination
mem_read_exe  in  1  EXE instruction is a single-cycle load
long_exe  in  1  EXE instruction is a long-latency op
alloc_valid  in  1  long op leaves EXE this cycle (already qualified by datapath)
cmpl_valid  in  1  long unit writeback this cycle
cmpl_tag  in  TAG_W  tag being completed
pc_sel_mem  in  1  taken branch/jump resolved in MEM
stall_pipl  in  1  external freeze (memory wait)
interrupt  in  1  interrupt request (level)
alloc_tag  out  TAG_W  tag assigned to the allocating op (combinational)
sb_full  out  1  all entries valid
sb_empty  out  1  no entries valid
irq_ack  out  1  one-cycle interrupt acknowledge
pc_reg_en, if_id_reg_en, id_exe_reg_en, exe_mem_reg_en, mem_wb_reg_en  out  1  pipeline register enables
if_id_reg_clr, id_exe_reg_clr, exe_mem_reg_clr, mem_wb_reg_clr  out  1  pipeline register synchronous clears
stall_count  out  CNT_W  saturating count of cycles with pc_reg_en=0

Behaviour:
- Scoreboard: NUM_TAGS entries of {valid, rd}.
- Allocation: on alloc_valid with rd_exe != 0 and not full, the lowest-index free entry is written at the clock edge. alloc_tag always shows the lowest free index, or 0 when full.
- Allocation with rd_exe == 0 writes no entry.
- Completion: cmpl_valid clears entry cmpl_tag at the edge. Completing an invalid entry is ignored. A freed entry is allocatable from the next cycle.
- Same-cycle alloc and cmpl are both applied; they cannot collide because alloc targets a free entry.
- alloc_valid while full is illegal; it is ignored and flagged by an assertion.
- raw_hz (comb): use_rsX_id and rsX_id != 0, and rsX_id matches any of:
  - a valid entry rd;
  - rd_exe when long_exe=1;
  - rd_exe when mem_read_exe=1.
- waw_hz (comb): reg_write_id, rd_id != 0, and rd_id matches a valid entry rd.
- struct_hz (comb): long_exe & sb_full.
- Control priority, highest first:
  1. stall_pipl: all en=0, all clr=0.
  2. pc_sel_mem: all en=1; if_id, id_exe, exe_mem clr=1; mem_wb clr=0.
  3. struct_hz: pc, if_id, id_exe, exe_mem en=0; exe_mem clr=1; mem_wb en=1.
  4. raw_hz | waw_hz: pc, if_id en=0; id_exe clr=1; remaining en=1.
  5. FSM in DRAIN: pc en=0; if_id clr=1; remaining en=1.
  6. Otherwise: all en=1, all clr=0.
- FSM states are RUN, DRAIN and ACK.
  - RUN → DRAIN on interrupt=1.
  - DRAIN → ACK when sb_empty & !long_exe & !stall_pipl.
  - ACK asserts irq_ack=1 for exactly one cycle, then → RUN.
  - interrupt deasserting during DRAIN returns the FSM to RUN with no ack.
  - pc_sel_mem during DRAIN flushes as in priority 2 and the FSM stays in DRAIN.
- stall_count increments each cycle pc_reg_en=0, saturates at all-ones and never wraps.
- Reset (asynchronous, any cycle, mid-drain included): all entries invalid, FSM=RUN, stall_count=0, irq_ack=0. Combinational outputs then settle to the idle values: all en=1, all clr=0, sb_empty=1, sb_full=0, alloc_tag=0.

Test Plan:
- Reset, NUM_TAGS=4: alloc_valid with rd_exe=5, 6, 7, 8 over 4 cycles → alloc_tag sequence 0, 1, 2, 3; sb_full=1; next long_exe=1 → struct stall, exe_mem_reg_clr=1.
- Entry {rd=5} pending, ID reads rs1=5 → pc_reg_en=0 and id_exe_reg_clr=1 until cmpl_valid with tag 0; the cycle after completion pc_reg_en=1.
- ID rs2=0 with rd=0 allocation attempted → no entry, no stall; ID writes rd=6 with entry {6} pending → waw stall.
- Stall and pc_sel_mem in the same cycle → flush wins; stall_pipl plus pc_sel_mem → all en=0, no clears.
- Two entries pending, interrupt=1 → DRAIN with if_id_reg_clr=1; after both complete, irq_ack pulses exactly 1 cycle. Reset asserted mid-DRAIN → FSM=RUN, sb_empty=1.
- CNT_W=4, stall held 20 cycles → stall_count stops at 15.
